cc_assoc_ctrl: RTL and testbench
================================

# cc_assoc_ctrl

Parametrised N-way set-associative read-only cache controller for the CacheController subsystem; the generalised successor of the direct-mapped top. It sits between the interconnect AXI read port and the memory AXI read port and drives a banked tag/data SRAM. Each hit or miss returns one full line as a wrap burst, critical word first; on a miss, beats are forwarded to the interconnect as they arrive from memory. It adds pseudo-LRU replacement, a per-way valid bit, and a hardware invalidate-all sweep that also runs automatically after reset.

## Interface
Derived widths: OFF_W=log2(LINE_BEATS*DATA_W/8), IDX_W=log2(SETS), TAG_W=32-IDX_W-OFF_W, LINE_W=LINE_BEATS*DATA_W. At defaults: 6/8/18/512.
- WAYS, 2, associativity; legal values 1, 2, 4.
- SETS, 256, sets per way; power of two.
- LINE_BEATS, 8, beats per line; power of two, 2..16.
- DATA_W, 64, AXI data width in bits; 32 or 64.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- inct_araddr_i  in  32  request byte address; the beat-aligned word selects the critical word.
- inct_arvalid_i  in  1  request valid.
- inct_arready_o  out  1  request accepted; reset 0.
- inct_rdata_o  out  DATA_W  read beat; reset 0.
- inct_rresp_o  out  2  OKAY on hits; forwarded mem_rresp_i on misses; reset 0.
- inct_rlast_o  out  1  asserted on beat LINE_BEATS-1; reset 0.
- inct_rvalid_o  out  1  beat valid; reset 0.
- inct_rready_i  in  1  beat ready.
- mem_araddr_o  out  32  {tag,index,word,zeros}, critical-word address; the top ties arlen=LINE_BEATS-1, arsize=log2(DATA_W/8), arburst=WRAP. Reset 0.
- mem_arvalid_o  out  1  miss request valid; reset 0.
- mem_arready_i  in  1  miss request ready.
- mem_rdata_i  in  DATA_W  fill beat.
- mem_rresp_i  in  2  fill beat response.
- mem_rvalid_i  in  1  fill beat valid.
- mem_rready_o  out  1  fill beat ready; reset 0.
- rden_o  out  1  SRAM read strobe; data returns the next cycle. Reset 0.
- raddr_o  out  IDX_W  SRAM read set index; reset 0.
- rdata_tag_i  in  WAYS*(TAG_W+1)  per-way {valid,tag}; way 0 in the LSBs.
- rdata_data_i  in  WAYS*LINE_W  per-way line data; way 0 in the LSBs.
- wren_o  out  1  SRAM write strobe; reset 0.
- waddr_o  out  IDX_W  SRAM write set index; reset 0.
- wway_o  out  WAYS  one-hot way write mask; all ones during a sweep. Reset 0.
- wdata_tag_o  out  TAG_W+1  {valid,tag} write data; reset 0.
- wdata_data_o  out  LINE_W  line write data; reset 0.
- inv_req_i  in  1  single-cycle pulse requesting invalidate-all.
- inv_busy_o  out  1  high while an invalidate is pending or running; reset 1.

## Operation
- **FSM states:** INV, IDLE, LOOKUP, HIT_SEND, MISS_AR, MISS_FILL, WRITE. Reset enters INV with set counter 0.
- **Request accept:** inct_arready_o = (IDLE & ~inv_pend & ~inv_req_i). A handshake latches the address, drives rden_o=1 and raddr_o=index combinationally, then moves to LOOKUP.
- **LOOKUP:** a way hits when its valid bit is 1 and its tag matches. On a hit, latch that way's line into the line buffer, mark the way MRU, increment beat counter k from 0, go to HIT_SEND. On a miss, select the victim and go to MISS_AR. If more than one way matches (SRAM corruption), take the lowest way.
- **Victim selection:** the lowest-index invalid way; otherwise the pLRU way. WAYS=1 always uses way 0. WAYS=2 uses one bit per set. WAYS=4 uses a 3-bit tree per set (b0 root, b1 covers ways 0/1, b2 covers ways 2/3). An access points the tree bits away from the used way. The LRU array is in flops and is cleared by rst and by the sweep.
- **HIT_SEND:** beat k is word (crit+k) mod LINE_BEATS of the line buffer, sent with inct_rresp_o=OKAY. k advances on rvalid&rready. The handshake of beat LINE_BEATS-1 returns to IDLE.
- **MISS_AR:** mem_arvalid_o=1 until mem_arready_i, then go to MISS_FILL.
- **MISS_FILL:** inct_rvalid_o=mem_rvalid_i, inct_rdata_o=mem_rdata_i, inct_rresp_o=mem_rresp_i, mem_rready_o=inct_rready_i, all combinational. Each accepted beat is stored at line word (crit+k) mod LINE_BEATS. Any non-OKAY beat sets a sticky err flag. The last beat goes to WRITE if err=0; otherwise it returns to IDLE and nothing is allocated.
- **WRITE:** one cycle of wren_o=1 to the victim set/way with {1,tag} and the line; mark the way MRU; go to IDLE.
- **Invalidate:** inv_req_i sets inv_pend (already set at reset). It is serviced only from IDLE, and in-flight requests always complete first. INV writes {0,0} to all ways of set s for s=0..SETS-1, one set per cycle, and clears LRU. inv_busy_o falls the cycle after the last write. Pulses received during INV are absorbed.

## Timing
- **Hit** (AR handshake at cycle T): LOOKUP at T+1; first rvalid at T+2. With rready held high, rlast is at T+1+LINE_BEATS and arready is high again at T+2+LINE_BEATS.
- **Miss:** mem_arvalid_o first high at T+2. Each fill beat reaches the interconnect in the same cycle it arrives. wren_o is high the cycle after the last fill handshake; arready is high the cycle after that.
- **Reset sweep:** starts in the first edge after rst falls and takes SETS cycles. Earliest arready is cycle SETS.
- **Same-cycle inv_req_i and arvalid in IDLE:** the invalidate wins and arready stays low.
- **Reset mid-burst:** all outputs return to their reset values, the beat is dropped, and a sweep follows.

## Test plan
- **Reset sweep:** assert rst, then release. Required: 256 wren_o cycles with waddr 0..255, wway=2'b11, wdata_tag 0; inv_busy_o then falls; arready first high at cycle 256.
- **Cold miss then hit** at 0x0000_1238 (crit word 7). Miss: mem_araddr=0x0000_1238; fill beats forwarded in order words 7,0,1..6; rlast on the 8th; one write to set 0x48 way 0 with tag 0. Repeat request: hit, same 8 words from SRAM, rresp OKAY, no mem AR.
- **WAYS=2 eviction:** fill tags A and B into set 5, hit A, then request tag C. Required: C replaces B (wway=2'b10). Subsequent B request misses; A still hits.
- **Fill error:** mem_rresp=SLVERR on beat 3 of a miss. Required: inct_rresp is SLVERR on that beat; no wren_o; the same address misses again.
- **Backpressure:** toggle inct_rready_i 1/0 during a hit and during a miss. Required: no beat lost or duplicated; mem_rready_o tracks inct_rready_i.
- **Invalidate collision:** inv_req_i pulses while in HIT_SEND. Required: the burst completes, then the 256-cycle sweep runs, then a prior-hit address misses.

Source files
------------

// File: rtl/cc_assoc_if.sv
// cc_assoc_if: interconnect-side and memory-side AXI read channels of the cache controller.
// slave is the controller's view; master is the surrounding system's view.
interface cc_assoc_if #(
    parameter int DATA_W = 64
);
    logic [31:0]       inct_araddr_i;
    logic              inct_arvalid_i;
    logic              inct_arready_o;
    logic [DATA_W-1:0] inct_rdata_o;
    logic [1:0]        inct_rresp_o;
    logic              inct_rlast_o;
    logic              inct_rvalid_o;
    logic              inct_rready_i;
    logic [31:0]       mem_araddr_o;
    logic              mem_arvalid_o;
    logic              mem_arready_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [1:0]        mem_rresp_i;
    logic              mem_rvalid_i;
    logic              mem_rready_o;

    modport slave (
        input  inct_araddr_i, inct_arvalid_i, inct_rready_i,
        output inct_arready_o, inct_rdata_o, inct_rresp_o, inct_rlast_o, inct_rvalid_o,
        input  mem_arready_i, mem_rdata_i, mem_rresp_i, mem_rvalid_i,
        output mem_araddr_o, mem_arvalid_o, mem_rready_o
    );

    modport master (
        output inct_araddr_i, inct_arvalid_i, inct_rready_i,
        input  inct_arready_o, inct_rdata_o, inct_rresp_o, inct_rlast_o, inct_rvalid_o,
        output mem_arready_i, mem_rdata_i, mem_rresp_i, mem_rvalid_i,
        input  mem_araddr_o, mem_arvalid_o, mem_rready_o
    );
endinterface

// File: rtl/cc_assoc_ctrl.sv
// cc_assoc_ctrl: N-way set-associative read-only cache controller with pLRU replacement,
// critical-word-first wrap bursts and an invalidate-all sweep that also runs after reset.
module cc_assoc_ctrl #(
    parameter  int WAYS       = 2,
    parameter  int SETS       = 256,
    parameter  int LINE_BEATS = 8,
    parameter  int DATA_W     = 64,
    localparam int OFF_W      = $clog2(LINE_BEATS * DATA_W / 8),
    localparam int IDX_W      = $clog2(SETS),
    localparam int TAG_W      = 32 - IDX_W - OFF_W,
    localparam int LINE_W     = LINE_BEATS * DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    cc_assoc_if.slave                 bus,
    output logic                      rden_o,
    output logic [IDX_W-1:0]          raddr_o,
    input  logic [WAYS*(TAG_W+1)-1:0] rdata_tag_i,
    input  logic [WAYS*LINE_W-1:0]    rdata_data_i,
    output logic                      wren_o,
    output logic [IDX_W-1:0]          waddr_o,
    output logic [WAYS-1:0]           wway_o,
    output logic [TAG_W:0]            wdata_tag_o,
    output logic [LINE_W-1:0]         wdata_data_o,
    input  logic                      inv_req_i,
    output logic                      inv_busy_o
);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int WB_W   = $clog2(LINE_BEATS);
    localparam int WW     = WAYS > 1 ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {INV, IDLE, LOOKUP, HIT_SEND, MISS_AR, MISS_FILL, WRITE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [WB_W-1:0]   k_q, k_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              err_q, err_d, inv_pend_q, inv_pend_d;
    logic [IDX_W-1:0]  set_q, set_d;
    logic [WW-1:0]     way_q, way_d;
    logic [2:0]        lru_q [SETS];
    logic [2:0]        lru_d [SETS];

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WB_W-1:0]   widx;
    logic [2:0]        lru_set;
    logic [1:0]        plru;
    logic [WAYS-1:0]   hit, vld;
    logic [WW-1:0]     hit_way, inv_way, victim;

    // Tree bits {b2,b1,b0} are rewritten to point away from the way just used.
    function automatic logic [2:0] touch(input logic [2:0] t, input logic [1:0] w);
        return WAYS == 4 ? (w[1] ? {~w[0], t[1], 1'b0} : {t[2], ~w[0], 1'b1}) : {2'b00, ~w[0]};
    endfunction

    assign tag     = addr_q[31 -: TAG_W];
    assign idx     = addr_q[OFF_W +: IDX_W];
    assign widx    = addr_q[BYTE_W +: WB_W] + k_q;
    assign lru_set = lru_q[idx];
    assign plru    = WAYS == 4 ? (lru_set[0] ? {1'b1, lru_set[2]} : {1'b0, lru_set[1]})
                               : {1'b0, WAYS == 2 && lru_set[0]};
    assign inv_busy_o = inv_pend_q | (state_q == INV);

    // Scanning downward leaves the lowest matching / lowest invalid way selected.
    always_comb begin
        hit     = '0;
        vld     = '0;
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            vld[w] = rdata_tag_i[w*(TAG_W+1) + TAG_W];
            hit[w] = vld[w] && rdata_tag_i[w*(TAG_W+1) +: TAG_W] == tag;
            if (hit[w]) hit_way = WW'(w);
            if (!vld[w]) inv_way = WW'(w);
        end
        victim = &vld ? WW'(plru) : inv_way;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        k_d        = k_q;
        line_d     = line_q;
        err_d      = err_q;
        set_d      = set_q;
        way_d      = way_q;
        lru_d      = lru_q;
        inv_pend_d = inv_pend_q | inv_req_i;
        bus.inct_arready_o = 1'b0;
        bus.inct_rdata_o   = '0;
        bus.inct_rresp_o   = 2'b00;
        bus.inct_rlast_o   = 1'b0;
        bus.inct_rvalid_o  = 1'b0;
        bus.mem_araddr_o   = '0;
        bus.mem_arvalid_o  = 1'b0;
        bus.mem_rready_o   = 1'b0;
        rden_o       = 1'b0;
        raddr_o      = '0;
        wren_o       = 1'b0;
        waddr_o      = '0;
        wway_o       = '0;
        wdata_tag_o  = '0;
        wdata_data_o = '0;
        case (state_q)
            INV: begin
                // Held off while rst is high so the sweep's first write lands on the edge after release.
                wren_o       = ~rst;
                waddr_o      = set_q;
                wway_o       = '1;
                lru_d[set_q] = '0;
                set_d        = set_q + 1'b1;
                if (set_q == IDX_W'(SETS - 1)) begin
                    state_d    = IDLE;
                    inv_pend_d = 1'b0;
                end
            end
            IDLE: begin
                bus.inct_arready_o = ~inv_pend_q & ~inv_req_i;
                rden_o  = bus.inct_arready_o & bus.inct_arvalid_i;
                raddr_o = rden_o ? bus.inct_araddr_i[OFF_W +: IDX_W] : '0;
                if (rden_o) begin
                    addr_d  = bus.inct_araddr_i;
                    state_d = LOOKUP;
                end else if (inv_pend_d) state_d = INV;
            end
            LOOKUP: begin
                k_d   = '0;
                err_d = 1'b0;
                if (|hit) begin
                    line_d     = rdata_data_i[hit_way*LINE_W +: LINE_W];
                    lru_d[idx] = touch(lru_set, 2'(hit_way));
                    state_d    = HIT_SEND;
                end else begin
                    way_d   = victim;
                    state_d = MISS_AR;
                end
            end
            HIT_SEND: begin
                bus.inct_rvalid_o = 1'b1;
                bus.inct_rdata_o  = line_q[widx*DATA_W +: DATA_W];
                bus.inct_rlast_o  = &k_q;
                if (bus.inct_rready_i) begin
                    k_d = k_q + 1'b1;
                    if (&k_q) state_d = IDLE;
                end
            end
            MISS_AR: begin
                bus.mem_arvalid_o = 1'b1;
                bus.mem_araddr_o  = addr_q & ~32'(DATA_W / 8 - 1);
                if (bus.mem_arready_i) state_d = MISS_FILL;
            end
            MISS_FILL: begin
                bus.inct_rvalid_o = bus.mem_rvalid_i;
                bus.inct_rdata_o  = bus.mem_rdata_i;
                bus.inct_rresp_o  = bus.mem_rresp_i;
                bus.inct_rlast_o  = bus.mem_rvalid_i & (&k_q);
                bus.mem_rready_o  = bus.inct_rready_i;
                if (bus.mem_rvalid_i & bus.inct_rready_i) begin
                    line_d[widx*DATA_W +: DATA_W] = bus.mem_rdata_i;
                    err_d = err_q | (|bus.mem_rresp_i);
                    k_d   = k_q + 1'b1;
                    if (&k_q) state_d = err_d ? IDLE : WRITE;
                end
            end
            WRITE: begin
                wren_o       = 1'b1;
                waddr_o      = idx;
                wway_o       = WAYS'(1) << way_q;
                wdata_tag_o  = {1'b1, tag};
                wdata_data_o = line_q;
                lru_d[idx]   = touch(lru_set, 2'(way_q));
                state_d      = IDLE;
            end
            default: state_d = INV;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INV;
            addr_q     <= '0;
            k_q        <= '0;
            line_q     <= '0;
            err_q      <= 1'b0;
            set_q      <= '0;
            way_q      <= '0;
            lru_q      <= '{default: '0};
            inv_pend_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            k_q        <= k_d;
            line_q     <= line_d;
            err_q      <= err_d;
            set_q      <= set_d;
            way_q      <= way_d;
            lru_q      <= lru_d;
            inv_pend_q <= inv_pend_d;
        end
    end
endmodule

// File: tb/tb_cc_assoc_ctrl.sv
// tb_cc_assoc_ctrl: directed bench for cc_assoc_ctrl at default parameters, with a
// behavioural tag/data SRAM and a memory side driven beat by beat from the sequence.
module tb_cc_assoc_ctrl;
    localparam int WAYS = 2, SETS = 256, LB = 8, DW = 64, IDX_W = 8, TAG_W = 18, LW = LB * DW;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    cc_assoc_if #(.DATA_W(DW)) bus ();
    logic                      rden, wren, inv_req, inv_busy;
    logic [IDX_W-1:0]          raddr, waddr;
    logic [WAYS-1:0]           wway;
    logic [TAG_W:0]            wdata_tag;
    logic [LW-1:0]             wdata_data;
    logic [WAYS*(TAG_W+1)-1:0] rdata_tag;
    logic [WAYS*LW-1:0]        rdata_data;
    logic [TAG_W:0]            tmem [WAYS][SETS];
    logic [LW-1:0]             dmem [WAYS][SETS];
    int tests = 0, fails = 0;

    cc_assoc_ctrl #(.WAYS(WAYS), .SETS(SETS), .LINE_BEATS(LB), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rden_o(rden), .raddr_o(raddr), .rdata_tag_i(rdata_tag), .rdata_data_i(rdata_data),
        .wren_o(wren), .waddr_o(waddr), .wway_o(wway), .wdata_tag_o(wdata_tag),
        .wdata_data_o(wdata_data), .inv_req_i(inv_req), .inv_busy_o(inv_busy)
    );

    always @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (wren && wway[w]) begin
                tmem[w][waddr] <= wdata_tag;
                dmem[w][waddr] <= wdata_data;
            end
            if (rden) begin
                rdata_tag[w*(TAG_W+1) +: TAG_W+1] <= tmem[w][raddr];
                rdata_data[w*LW +: LW]            <= dmem[w][raddr];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] fdata(input logic [31:0] a);
        return {a, a ^ 32'hA5A5_5A5A};
    endfunction

    function automatic logic [LW-1:0] fline(input logic [31:0] a);
        logic [LW-1:0] l;
        for (int w = 0; w < LB; w++) l[w*DW +: DW] = fdata({a[31:6], 6'(w * 8)});
        return l;
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic req(input logic [31:0] a);
        nxt();
        bus.inct_araddr_i  = a;
        bus.inct_arvalid_i = 1'b1;
        smp();
        chk("arready", bus.inct_arready_o, 1);
        chk("rden", rden, 1);
        chk("raddr", raddr, a[13:6]);
        nxt();
        bus.inct_arvalid_i = 1'b0;
        smp();
        chk("lookup_rvalid", bus.inct_rvalid_o, 0);
    endtask

    task automatic hit(input logic [31:0] a, input bit bp, input bit inv);
        int j = 0, g = 0;
        logic rr;
        logic [2:0] wd;
        req(a);
        while (j < LB && g < 40) begin
            nxt();
            rr = bp ? g[0] : 1'b1;
            wd = 3'(a[5:3] + j);
            bus.inct_rready_i = rr;
            inv_req = inv && g == 1;
            smp();
            chk("hit_rvalid", bus.inct_rvalid_o, 1);
            chk("hit_rdata", bus.inct_rdata_o, fdata({a[31:6], wd, 3'b000}));
            chk("hit_rresp", bus.inct_rresp_o, 0);
            chk("hit_rlast", bus.inct_rlast_o, j == LB - 1);
            chk("hit_no_mem_ar", bus.mem_arvalid_o, 0);
            if (rr) j++;
            g++;
        end
        chk("hit_beats", j, LB);
        nxt();
        bus.inct_rready_i = 1'b1;
        inv_req = 1'b0;
        smp();
        chk("hit_done_arready", bus.inct_arready_o, !inv);
        chk("hit_done_rvalid", bus.inct_rvalid_o, 0);
        if (inv) chk("hit_inv_busy", inv_busy, 1);
    endtask

    task automatic miss(input logic [31:0] a, input bit bp, input int eb, input logic [WAYS-1:0] ew);
        int j = 0, g = 0;
        logic rr;
        logic [2:0] wd;
        req(a);
        nxt();
        smp();
        chk("mem_arvalid", bus.mem_arvalid_o, 1);
        chk("mem_araddr", bus.mem_araddr_o, {a[31:3], 3'b000});
        while (j < LB && g < 40) begin
            nxt();
            rr = bp ? g[0] : 1'b1;
            wd = 3'(a[5:3] + j);
            bus.inct_rready_i = rr;
            bus.mem_rvalid_i  = 1'b1;
            bus.mem_rdata_i   = fdata({a[31:6], wd, 3'b000});
            bus.mem_rresp_i   = (j == eb) ? 2'b10 : 2'b00;
            smp();
            chk("fill_rvalid", bus.inct_rvalid_o, 1);
            chk("fill_rdata", bus.inct_rdata_o, fdata({a[31:6], wd, 3'b000}));
            chk("fill_rresp", bus.inct_rresp_o, (j == eb) ? 2 : 0);
            chk("fill_rlast", bus.inct_rlast_o, j == LB - 1);
            chk("fill_mem_rready", bus.mem_rready_o, rr);
            if (rr) j++;
            g++;
        end
        chk("fill_beats", j, LB);
        nxt();
        bus.mem_rvalid_i  = 1'b0;
        bus.mem_rresp_i   = 2'b00;
        bus.inct_rready_i = 1'b1;
        smp();
        if (eb < 0) begin
            chk("wr_wren", wren, 1);
            chk("wr_waddr", waddr, a[13:6]);
            chk("wr_wway", wway, ew);
            chk("wr_tag", wdata_tag, {1'b1, a[31:14]});
            chk("wr_data", wdata_data, fline(a));
            nxt();
            smp();
        end
        chk("miss_done_wren", wren, 0);
        chk("miss_done_arready", bus.inct_arready_o, 1);
    endtask

    task automatic sweep();
        int bad = 0;
        for (int i = 0; i < SETS; i++) begin
            if (!(wren === 1'b1 && waddr === 8'(i) && wway === 2'b11 && wdata_tag === '0 &&
                  bus.inct_arready_o === 1'b0 && inv_busy === 1'b1)) bad++;
            nxt();
            smp();
        end
        chk("sweep_bad_cycles", bad, 0);
        chk("sweep_busy_low", inv_busy, 0);
        chk("sweep_arready", bus.inct_arready_o, 1);
        chk("sweep_wren_off", wren, 0);
    endtask

    initial begin
        logic [31:0] a_addr, b_addr, c_addr, d_addr;
        a_addr = 32'h0000_4140;
        b_addr = 32'h0000_8150;
        c_addr = 32'h0000_C178;
        d_addr = 32'h0000_2040;
        bus.inct_araddr_i  = '0;
        bus.inct_arvalid_i = 1'b0;
        bus.inct_rready_i  = 1'b1;
        bus.mem_arready_i  = 1'b1;
        bus.mem_rdata_i    = '0;
        bus.mem_rresp_i    = 2'b00;
        bus.mem_rvalid_i   = 1'b0;
        inv_req = 1'b0;
        repeat (2) @(posedge clk);
        smp();
        chk("rst_arready", bus.inct_arready_o, 0);
        chk("rst_rvalid", bus.inct_rvalid_o, 0);
        chk("rst_rlast", bus.inct_rlast_o, 0);
        chk("rst_mem_arvalid", bus.mem_arvalid_o, 0);
        chk("rst_mem_rready", bus.mem_rready_o, 0);
        chk("rst_wren", wren, 0);
        chk("rst_rden", rden, 0);
        chk("rst_busy", inv_busy, 1);
        nxt();
        rst = 1'b0;
        smp();
        sweep();
        miss(32'h0000_1238, 1'b0, -1, 2'b01);
        hit(32'h0000_1238, 1'b0, 1'b0);
        miss(a_addr, 1'b0, -1, 2'b01);
        miss(b_addr, 1'b0, -1, 2'b10);
        hit(a_addr, 1'b0, 1'b0);
        miss(c_addr, 1'b0, -1, 2'b10);
        hit(a_addr, 1'b0, 1'b0);
        miss(b_addr, 1'b0, -1, 2'b10);
        hit(a_addr, 1'b0, 1'b0);
        miss(d_addr, 1'b1, 3, 2'b01);
        miss(d_addr, 1'b0, -1, 2'b01);
        hit(32'h0000_1210, 1'b1, 1'b0);
        hit(32'h0000_1238, 1'b0, 1'b1);
        nxt();
        smp();
        sweep();
        miss(32'h0000_1238, 1'b0, -1, 2'b01);
        nxt();
        bus.inct_araddr_i  = a_addr;
        bus.inct_arvalid_i = 1'b1;
        inv_req = 1'b1;
        smp();
        chk("collide_arready", bus.inct_arready_o, 0);
        chk("collide_rden", rden, 0);
        nxt();
        bus.inct_arvalid_i = 1'b0;
        inv_req = 1'b0;
        smp();
        sweep();
        miss(a_addr, 1'b0, -1, 2'b01);
        req(a_addr);
        nxt();
        smp();
        chk("midburst_rvalid", bus.inct_rvalid_o, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_rvalid", bus.inct_rvalid_o, 0);
        chk("midrst_rlast", bus.inct_rlast_o, 0);
        chk("midrst_arready", bus.inct_arready_o, 0);
        chk("midrst_wren", wren, 0);
        chk("midrst_busy", inv_busy, 1);
        nxt();
        rst = 1'b0;
        smp();
        sweep();
        miss(a_addr, 1'b0, -1, 2'b01);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
